counter_sequencer: RTL

- Shares one COUNT_WIDTH-bit up-counter between NUM_REQ requesters using round-robin arbitration.
- A granted requester owns the counter for a programmed number of enabled ticks, then receives a one-cycle done pulse.
- Sits in front of the board-level counter datapath and drives its enable; exports the counter value to the board outputs.

---
 rtl/counter_sequencer_pkg.sv | 57 +++++
 rtl/counter_core.sv | 34 +++
 rtl/counter_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sequencer_pkg
//  Description : Shared types, default widths and the round-robin picker
//                used by the counter sequencer.
//                Contents: state_t (IDLE/RUN/DONE, binary encoded),
//                rr_pick_t {valid, idx}, rr_pick(req, ptr, num).
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_sequencer_pkg;

    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_COUNT_WIDTH = 4;

    // The picker works on a fixed-width request vector so one function
    // serves every legal NUM_REQ (2..8); unused upper bits are tied low.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request bit strictly after ptr, searching upward and
    // wrapping modulo num. The previous owner therefore has lowest priority.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 num
    );
        rr_pick_t         pick;
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        pick.valid = 1'b0;
        pick.idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= num && !pick.valid) begin
                cand     = (int'(ptr) + k) % num;
                cand_idx = cand[IDX_W-1:0];
                if (req[cand_idx]) begin
                    pick.valid = 1'b1;
                    pick.idx   = cand_idx;
                end
            end
        end
        return pick;
    endfunction

endpackage : counter_sequencer_pkg
`default_nettype wire

// File: rtl/counter_core.sv
`default_nettype none
// ============================================================================
//  Module      : counter_core
//  Description : COUNT_WIDTH-bit up-counter with synchronous clear and
//                increment enable. Clear has priority over enable.
//  Ports       : clk, rst (async, active-high), i_clear, i_enable, o_count
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_core #(
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_enable,
    output logic [COUNT_WIDTH-1:0] o_count
);

    logic [COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : counter_core
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sequencer
//  Description : Round-robin sharing of one up-counter between NUM_REQ
//                requesters. The owner holds the counter for its programmed
//                number of enabled ticks, then gets a one-cycle done pulse.
//  Ports       : clock_i, reset_i (async, active-high)
//                req_i[NUM_REQ]       request levels
//                target_i[NUM_REQ*CW] packed per-requester targets
//                abort_i              abort current run
//                grant_o, done_o      one-hot owner / completion pulse
//                busy_o               high in RUN and DONE
//                counter_enable_o     increment strobe (combinational)
//                counter_value_o      current count
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] target_i,
    input  logic                           abort_i,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic [NUM_REQ-1:0]             done_o,
    output logic                           busy_o,
    output logic                           counter_enable_o,
    output logic [COUNT_WIDTH-1:0]         counter_value_o
);

    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [IDX_W-1:0] C_PTR_RESET = IDX_W'(NUM_REQ - 1);

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_owner, w_owner_nxt;
    logic [IDX_W-1:0]       r_ptr,   w_ptr_nxt;
    logic [COUNT_WIDTH-1:0] r_target, w_target_nxt;

    logic [NUM_REQ-1:0]     r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]     r_done,  w_done_nxt;
    logic                   r_busy,  w_busy_nxt;

    logic [MAX_REQ-1:0]     w_req_pad;
    rr_pick_t               w_pick;
    logic [COUNT_WIDTH-1:0] w_target_sel;
    logic [COUNT_WIDTH-1:0] w_count;
    logic                   w_abort;
    logic                   w_at_target;
    logic                   w_clear;
    logic                   w_enable;

    always_comb begin
        w_req_pad              = '0;
        w_req_pad[NUM_REQ-1:0] = req_i;
    end

    assign w_pick = rr_pick(w_req_pad, r_ptr, NUM_REQ);

    always_comb begin
        w_target_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick.idx == IDX_W'(k)) begin
                w_target_sel = target_i[k*COUNT_WIDTH +: COUNT_WIDTH];
            end
        end
    end

    // Dropping the owner's request is treated exactly like abort_i.
    assign w_abort     = (r_state == ST_RUN) && (abort_i || !w_req_pad[r_owner]);
    assign w_at_target = (w_count == r_target);

    // ------------------------------------------------------------------
    // State register (with owner, target and round-robin pointer)
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_target <= '0;
            r_ptr    <= C_PTR_RESET;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_target <= w_target_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_target_nxt = r_target;
        w_ptr_nxt    = r_ptr;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick.valid) begin
                    w_state_nxt  = ST_RUN;
                    w_owner_nxt  = w_pick.idx;
                    w_target_nxt = w_target_sel;
                    w_clear      = 1'b1;
                end
            end
            ST_RUN: begin
                // Abort is checked first so it beats a simultaneous finish.
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_owner;
                end else if (w_at_target) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = r_owner;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs, plus the
    // combinational enable. Enable is also gated by abort so an aborted
    // run leaves the counter at the value it had when abort was seen.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_grant_nxt[k] = (w_state_nxt == ST_RUN)  && (w_owner_nxt == IDX_W'(k));
            w_done_nxt[k]  = (w_state_nxt == ST_DONE) && (w_owner_nxt == IDX_W'(k));
        end
        w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE);
        w_enable   = (r_state == ST_RUN) && !w_at_target && !w_abort;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    counter_core #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter_core (
        .clk      (clock_i),
        .rst      (reset_i),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_count  (w_count)
    );

    assign grant_o          = r_grant;
    assign done_o           = r_done;
    assign busy_o           = r_busy;
    assign counter_enable_o = w_enable;
    assign counter_value_o  = w_count;

endmodule : counter_sequencer
`default_nettype wire
